sdio_txframe: RTL and testbench

- Parametrised transmit data framer for the SDIO data path. It sits between the controller's TX FIFO stream and the frontend's per-lane data outputs.
- Serialises one block onto 1, 4 or 8 lanes, selected at run time. Each frame is a start bit, then MSB-first data, then a per-lane CRC16, then a stop bit.
- The frontend paces the framer with one bit-time strobe per SD clock period.

---
 rtl/sdio_txframe.sv | 214 +++++++++++++++++++++
 tb/tb_sdio_txframe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_txframe.sv
// SDIO TX data framer: start bit, MSB-first data, per-lane CRC16, stop bit on 1/4/8 lanes, paced by i_ckstb.
// Optional SDIO_TXFRAME_BUSYWAIT_EN: hold o_busy after the stop bit until the card releases DAT0.
module sdio_txframe #(
   parameter int NUMIO = 4,
   parameter int LGBLK = 9,
   parameter int MW    = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [1:0]       i_cfg_width,
   input  logic [LGBLK:0]   i_length,
   input  logic             i_start,
   input  logic             i_ckstb,
   input  logic             i_card_busy,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [MW-1:0]    s_data,
   output logic             o_data_en,
   output logic [NUMIO-1:0] o_tx_data,
   output logic             o_stall,
   output logic             o_busy,
   output logic             o_done
);
   localparam int CW = LGBLK + 4;
   localparam logic [LGBLK:0] MAXLEN = (LGBLK+1)'(1) << LGBLK;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_CRC, S_STOP
`ifdef SDIO_TXFRAME_BUSYWAIT_EN
      , S_BUSYWAIT
`endif
   } state_t;

   state_t          state, state_nxt;
   logic [1:0]      wsel;
   logic [MW-1:0]   sreg, sreg_sh;
   logic [CW-1:0]   dcnt;
   logic [4:0]      wpos, wlast;
   logic [3:0]      ccnt;
   logic [15:0]     crc [NUMIO];
   logic            done;
   logic [NUMIO-1:0] act, dbit;
   logic            boundary, advance, last_step;
   logic [LGBLK:0]  len_bytes;
   logic [CW-1:0]   total_bits, total_stb;
`ifdef SDIO_TXFRAME_BUSYWAIT_EN
   logic [1:0]      gcnt;
`endif

   function automatic logic [1:0] lane_code(input logic [1:0] c);
      if (c == 2'd2 && NUMIO >= 8) return 2'd2;
      if ((c == 2'd1 || c == 2'd2) && NUMIO >= 4) return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [15:0] crc_next(input logic [15:0] c, input logic b);
      return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
   endfunction

   assign len_bytes  = (i_length[LGBLK:2] == '0) ? MAXLEN : {i_length[LGBLK:2], 2'b00};
   assign total_bits = {len_bytes, 3'b000};

   always_comb begin
      case (lane_code(i_cfg_width))
         2'd2:    total_stb = total_bits >> 3;
         2'd1:    total_stb = total_bits >> 2;
         default: total_stb = total_bits;
      endcase
   end

   // Lane i carries the i-th least significant bit of the w-bit chunk at the top of the shifter
   always_comb begin
      act = '0;
      dbit = '1;
      for (int i = 0; i < NUMIO; i++) begin
         case (wsel)
            2'd2: begin
               act[i]  = 1'b1;
               dbit[i] = sreg[MW-8+(i%8)];
            end
            2'd1: if (i < 4) begin
               act[i]  = 1'b1;
               dbit[i] = sreg[MW-4+(i%4)];
            end
            default: if (i == 0) begin
               act[i]  = 1'b1;
               dbit[i] = sreg[MW-1];
            end
         endcase
      end
   end

   always_comb begin
      case (wsel)
         2'd2:    begin sreg_sh = sreg << 8; wlast = 5'd3;  end
         2'd1:    begin sreg_sh = sreg << 4; wlast = 5'd7;  end
         default: begin sreg_sh = sreg << 1; wlast = 5'd31; end
      endcase
   end

   // A word load is due at START and on the last strobe of every word except the final one
   assign boundary  = (state == S_START) || (state == S_DATA && wpos == wlast && dcnt != CW'(1));
   assign s_ready   = boundary && i_ckstb;
   assign o_stall   = boundary && !s_valid;
   assign advance   = i_ckstb && !o_stall;
   assign last_step = (state != S_IDLE) && (state_nxt == S_IDLE);

   always_ff @(posedge i_clk) begin
      if (i_reset) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (i_start) state_nxt = S_START;
         S_START: if (advance) state_nxt = S_DATA;
         S_DATA:  if (advance && dcnt == CW'(1)) state_nxt = S_CRC;
         S_CRC:   if (i_ckstb && ccnt == 4'd15) state_nxt = S_STOP;
`ifdef SDIO_TXFRAME_BUSYWAIT_EN
         S_STOP:  if (i_ckstb) state_nxt = S_BUSYWAIT;
         S_BUSYWAIT: if (i_ckstb && gcnt == 2'd0 && !i_card_busy) state_nxt = S_IDLE;
`else
         S_STOP:  if (i_ckstb) state_nxt = S_IDLE;
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wsel <= 2'd0;
         sreg <= '0;
         dcnt <= '0;
         wpos <= '0;
         ccnt <= '0;
         done <= 1'b0;
         for (int i = 0; i < NUMIO; i++) crc[i] <= '0;
`ifdef SDIO_TXFRAME_BUSYWAIT_EN
         gcnt <= '0;
`endif
      end else begin
         done <= last_step;
         case (state)
            S_IDLE: if (i_start) begin
               wsel <= lane_code(i_cfg_width);
               dcnt <= total_stb;
               wpos <= '0;
               ccnt <= '0;
               for (int i = 0; i < NUMIO; i++) crc[i] <= '0;
            end
            S_START: if (advance) begin
               sreg <= s_data;
               wpos <= '0;
            end
            S_DATA: if (advance) begin
               for (int i = 0; i < NUMIO; i++)
                  if (act[i]) crc[i] <= crc_next(crc[i], dbit[i]);
               dcnt <= dcnt - 1'b1;
               if (wpos == wlast) begin
                  sreg <= s_data;
                  wpos <= '0;
               end else begin
                  sreg <= sreg_sh;
                  wpos <= wpos + 1'b1;
               end
            end
            S_CRC: if (i_ckstb) begin
               for (int i = 0; i < NUMIO; i++) crc[i] <= {crc[i][14:0], 1'b0};
               ccnt <= ccnt + 1'b1;
            end
`ifdef SDIO_TXFRAME_BUSYWAIT_EN
            // Two grace strobes before DAT0 is trusted to reflect card busy
            S_STOP: if (i_ckstb) gcnt <= 2'd2;
            S_BUSYWAIT: if (i_ckstb && gcnt != 2'd0) gcnt <= gcnt - 1'b1;
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      o_tx_data = '1;
      o_data_en = 1'b0;
      o_busy    = (state != S_IDLE);
      o_done    = done;
      case (state)
         S_START: begin
            o_data_en = 1'b1;
            o_tx_data = ~act;
         end
         S_DATA: begin
            o_data_en = 1'b1;
            o_tx_data = dbit;
         end
         S_CRC: begin
            o_data_en = 1'b1;
            for (int i = 0; i < NUMIO; i++)
               if (act[i]) o_tx_data[i] = crc[i][15];
         end
         S_STOP: o_data_en = 1'b1;
         default: ;
      endcase
   end

`ifdef SDIO_TXFRAME_BUSYWAIT_EN
   logic unused_bits;
   assign unused_bits = ^i_length[1:0];
`else
   logic unused_bits;
   assign unused_bits = ^{i_length[1:0], i_card_busy};
`endif

endmodule

// File: tb/tb_sdio_txframe.sv
// Directed bench for sdio_txframe built with 8 lanes so 1/4/8-lane modes are all reachable.
module tb_sdio_txframe;
   logic        clk = 1'b0;
   logic        i_reset, i_start, i_ckstb, i_card_busy, s_valid;
   logic [1:0]  i_cfg_width;
   logic [9:0]  i_length;
   logic [31:0] s_data;
   logic        s_ready, o_data_en, o_stall, o_busy, o_done;
   logic [7:0]  o_tx_data;

   always #5 clk = ~clk;

   sdio_txframe #(.NUMIO(8), .LGBLK(9), .MW(32)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_cfg_width(i_cfg_width), .i_length(i_length),
      .i_start(i_start), .i_ckstb(i_ckstb), .i_card_busy(i_card_busy),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .o_data_en(o_data_en), .o_tx_data(o_tx_data), .o_stall(o_stall),
      .o_busy(o_busy), .o_done(o_done)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] words[$];
   logic [7:0]  stream[$], exp_q[$], ref_q[$];
   logic [15:0] exp_crc [8];
   int accepted, done_cnt, nstall, frozen_bad, post_stb;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, expv);
      end
   endtask

   function automatic logic [7:0] sget(input int k);
      if (k < stream.size()) return stream[k];
      return 8'h00;
   endfunction

   function automatic logic getbit(input int n);
      logic [31:0] wd;
      wd = words[n / 32];
      return wd[31 - (n % 32)];
   endfunction

   // Reference frame: chunk MSB on the highest active lane, CRC16-CCITT per lane
   function automatic void build_exp(input int w, input int nbytes);
      logic [15:0] c [8];
      logic [7:0]  v;
      logic        b, fb;
      int          nstb;
      nstb = nbytes * 8 / w;
      exp_q.delete();
      for (int i = 0; i < 8; i++) c[i] = 16'h0000;
      v = 8'hFF;
      for (int i = 0; i < w; i++) v[i] = 1'b0;
      exp_q.push_back(v);
      for (int s = 0; s < nstb; s++) begin
         v = 8'hFF;
         for (int i = 0; i < w; i++) begin
            b    = getbit(s * w + (w - 1 - i));
            v[i] = b;
            fb   = b ^ c[i][15];
            c[i] = {c[i][14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
         end
         exp_q.push_back(v);
      end
      for (int t = 0; t < 16; t++) begin
         v = 8'hFF;
         for (int i = 0; i < w; i++) v[i] = c[i][15 - t];
         exp_q.push_back(v);
      end
      exp_q.push_back(8'hFF);
      for (int i = 0; i < 8; i++) exp_crc[i] = c[i];
   endfunction

   task automatic cmp_stream(input string tag);
      int nb;
      nb = 0;
      check({tag, "_len"}, 64'(stream.size()), 64'(exp_q.size()));
      for (int k = 0; k < stream.size() && k < exp_q.size(); k++)
         if (stream[k] !== exp_q[k]) nb++;
      check({tag, "_bits"}, 64'(nb), 64'd0);
   endtask

   task automatic run_frame(input logic [1:0] code, input logic [9:0] len, input int stall_idx,
                            input int abort_at, input string tag);
      int idx, cyc, nst;
      logic [7:0] frz;
      bit done_seen, aborted;
      stream.delete();
      accepted = 0; done_cnt = 0; frozen_bad = 0; post_stb = 0;
      idx = 0; cyc = 0; nst = 0; frz = 8'h00; done_seen = 0; aborted = 0;
      @(negedge clk);
      i_cfg_width = code; i_length = len; i_start = 1'b1; i_ckstb = 1'b0; s_valid = 1'b0;
      @(negedge clk);
      i_start = 1'b0;
      i_cfg_width = code ^ 2'b01;
      i_length = len ^ 10'h008;
      check({tag, "_busy_rise"}, 64'(o_busy), 64'd1);
      while (!done_seen && !aborted && cyc < 6000) begin
         i_ckstb     = cyc[0];
         s_valid     = !(idx == stall_idx && nst < 5);
         s_data      = (idx < words.size()) ? words[idx] : 32'hDEAD_BEEF;
         i_start     = (cyc == 9);
         i_card_busy = (post_stb < 20);
         #1;
         if (i_ckstb) begin
            if (o_stall) begin
               nst++;
               if (nst == 1) frz = o_tx_data;
               else if (o_tx_data !== frz) frozen_bad++;
            end else if (o_data_en) stream.push_back(o_tx_data);
            else if (o_busy) post_stb++;
            if (s_ready && s_valid) begin
               accepted++;
               idx++;
            end
         end
         if (abort_at >= 0 && stream.size() == abort_at) begin
            i_reset = 1'b1;
            @(negedge clk);
            i_reset = 1'b0; i_ckstb = 1'b0; i_start = 1'b0;
            #1;
            check({tag, "_rst_en"},    64'(o_data_en), 64'd0);
            check({tag, "_rst_lanes"}, 64'(o_tx_data), 64'hFF);
            check({tag, "_rst_busy"},  64'(o_busy),    64'd0);
            check({tag, "_rst_done"},  64'(o_done),    64'd0);
            aborted = 1;
         end else begin
            @(negedge clk);
            cyc++;
            if (o_done) begin
               done_cnt++;
               done_seen = 1;
               check({tag, "_busy_fall"}, 64'(o_busy), 64'd0);
            end
         end
      end
      nstall = nst;
      i_ckstb = 1'b0; s_valid = 1'b0; i_start = 1'b0;
      if (!done_seen && !aborted) check({tag, "_timeout"}, 64'd0, 64'd1);
      repeat (3) begin
         @(negedge clk);
         if (o_done) done_cnt++;
      end
   endtask

   initial begin
      logic [31:0] d;
      logic [7:0]  v, andv, orv;
      int          nd;
      i_reset = 1'b1; i_start = 1'b0; i_ckstb = 1'b0; i_card_busy = 1'b0;
      s_valid = 1'b0; s_data = '0; i_cfg_width = 2'd0; i_length = '0;
      repeat (3) @(negedge clk);
      check("rst_en",    64'(o_data_en), 64'd0);
      check("rst_lanes", 64'(o_tx_data), 64'hFF);
      check("rst_ready", 64'(s_ready),   64'd0);
      check("rst_stall", 64'(o_stall),   64'd0);
      check("rst_busy",  64'(o_busy),    64'd0);
      check("rst_done",  64'(o_done),    64'd0);
      i_reset = 1'b0;

      // 1 lane, one word
      words = '{32'hA5A5_0F0F};
      run_frame(2'd0, 10'd4, -1, -1, "t1");
      build_exp(1, 4);
      cmp_stream("t1");
      check("t1_nstb",  64'(stream.size()), 64'd50);
      check("t1_start", 64'(sget(0)),  64'hFE);
      check("t1_stop",  64'(sget(49)), 64'hFF);
      d = '0; andv = 8'hFF;
      for (int k = 1; k <= 32; k++) begin
         v = sget(k);
         d = {d[30:0], v[0]};
      end
      for (int k = 0; k < 50; k++) begin
         v = sget(k);
         andv = andv & {v[7:1], 1'b1};
      end
      check("t1_data",  64'(d),    64'hA5A5_0F0F);
      check("t1_upper", 64'(andv), 64'hFF);
      d = '0;
      for (int k = 33; k <= 48; k++) begin
         v = sget(k);
         d = {d[30:0], v[0]};
      end
      check("t1_crc",   64'(d), 64'(exp_crc[0]));
      check("t1_ready", 64'(accepted), 64'd1);
      check("t1_done",  64'(done_cnt), 64'd1);
`ifdef SDIO_TXFRAME_BUSYWAIT_EN
      check("t1_bwait", 64'(post_stb), 64'd21);
`else
      check("t1_bwait", 64'(post_stb), 64'd0);
`endif

      // 4 lanes, full 512-byte block via the 0 length encoding
      words.delete();
      for (int k = 0; k < 128; k++) words.push_back(32'h0);
      run_frame(2'd1, 10'd0, -1, -1, "t2");
      build_exp(4, 512);
      cmp_stream("t2");
      check("t2_nstb",  64'(stream.size()), 64'd1042);
      check("t2_start", 64'(sget(0)), 64'hF0);
      orv = 8'h00;
      for (int k = 1025; k <= 1040; k++) orv = orv | sget(k);
      check("t2_crc",   64'(orv), 64'hF0);
      check("t2_words", 64'(accepted), 64'd128);
      check("t2_done",  64'(done_cnt), 64'd1);

      // 8 lanes, byte per strobe
      words = '{32'h0102_0304, 32'h0506_0708};
      run_frame(2'd2, 10'd8, -1, -1, "t3");
      build_exp(8, 8);
      cmp_stream("t3");
      check("t3_start", 64'(sget(0)), 64'h00);
      for (int k = 1; k <= 8; k++) check($sformatf("t3_byte%0d", k), 64'(sget(k)), 64'(k));
      check("t3_words", 64'(accepted), 64'd2);

      // 4 lanes, starved at the second word boundary
      words = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C, 32'h4B5A_6978};
      run_frame(2'd1, 10'd16, -1, -1, "t4a");
      ref_q = stream;
      run_frame(2'd1, 10'd16, 1, -1, "t4b");
      build_exp(4, 16);
      cmp_stream("t4b");
      check("t4_nstall", 64'(nstall), 64'd5);
      check("t4_frozen", 64'(frozen_bad), 64'd0);
      nd = (ref_q.size() == stream.size()) ? 0 : 1;
      for (int k = 0; k < ref_q.size() && k < stream.size(); k++)
         if (ref_q[k] !== stream[k]) nd++;
      check("t4_same", 64'(nd), 64'd0);
      check("t4_words", 64'(accepted), 64'd4);

      // Reset at data bit 100, then a clean frame
      run_frame(2'd0, 10'd16, -1, 101, "t5a");
      run_frame(2'd0, 10'd16, -1, -1, "t5b");
      build_exp(1, 16);
      cmp_stream("t5b");
      check("t5_done", 64'(done_cnt), 64'd1);

      // Width code 3 behaves as 1 lane; length low bits ignored
      words = '{32'hC3C3_5A5A};
      run_frame(2'd3, 10'd7, -1, -1, "t6");
      build_exp(1, 4);
      cmp_stream("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
